// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset constants and the RV32C
// instruction length decode used by fetch and by decode for link values.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   // Byte length of an instruction from its two lowest bits: 2'b11 marks a
   // 32-bit encoding, anything else is a 16-bit compressed instruction.
   function automatic logic [2:0] instr_len(input logic [1:0] lsb);
      return (lsb == 2'b11) ? 3'd4 : 3'd2;
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a 1-cycle-latency halfword-addressable
// instruction memory and hands one instruction per cycle to decode over a
// valid/ready handshake. Supports 16/32-bit instructions, redirects and
// fetch gating while the program loader owns the memory.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP      = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en_i,
   input  logic        jump_en_i,
   input  logic [15:0] jump_addr_i,
   output logic [15:0] mem_addr_o,
   output logic        mem_rd_en_o,
   input  logic [31:0] mem_rd_data_i,
   output logic [31:0] instr_o,
   output logic [15:0] instr_pc_o,
   output logic        instr_valid_o,
   input  logic        id_ready_i
);

   // Addresses are halfword aligned throughout, so the reset PC is too.
   localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

   fetch_state_t state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  req_pc_q, req_pc_d;
   logic [31:0]  hold_instr_q, hold_instr_d;

   logic [31:0]  cur_instr;
   logic [15:0]  seq_pc;
   logic [15:0]  jump_pc;
   logic [15:0]  addr;
   logic         rd_en;
   logic         valid;
   logic         unused_jump_lsb;

   assign unused_jump_lsb = jump_addr_i[0];
   assign jump_pc         = {jump_addr_i[15:1], 1'b0};
   assign cur_instr       = (state_q == HOLD) ? hold_instr_q : mem_rd_data_i;
   // 16-bit wrapping add; this is the mem_rd_data -> mem_addr next-PC loop.
   assign seq_pc          = req_pc_q + {13'd0, instr_len(cur_instr[1:0])};

   // Next-state, memory request and presentation decode.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      hold_instr_d = hold_instr_q;
      addr         = req_pc_q;
      rd_en        = 1'b0;
      valid        = 1'b0;
      unique case (state_q)
         IDLE: begin
            // jump_en is deliberately ignored here.
            if (fetch_en_i) begin
               addr     = pc_q;
               rd_en    = 1'b1;
               req_pc_d = pc_q;
               state_d  = RUN;
            end
         end
         RUN, HOLD: begin
            if (jump_en_i) begin
               addr     = jump_pc;
               rd_en    = 1'b1;
               req_pc_d = jump_pc;
               state_d  = RUN;
            end else if (!fetch_en_i) begin
               // Unconsumed instruction is refetched from req_pc on re-enable.
               pc_d    = req_pc_q;
               state_d = IDLE;
            end else if (id_ready_i) begin
               valid    = 1'b1;
               addr     = seq_pc;
               rd_en    = 1'b1;
               req_pc_d = seq_pc;
               state_d  = RUN;
            end else begin
               valid        = 1'b1;
               hold_instr_d = cur_instr;
               state_d      = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; instr shows NOP whenever nothing valid is presented.
   always_comb begin
      mem_addr_o    = addr;
      // Keep the memory idle while reset is asserted, even with fetch_en high.
      mem_rd_en_o   = rd_en & rst_n;
      instr_valid_o = valid;
      instr_o       = valid ? cur_instr : NOP;
      instr_pc_o    = req_pc_q;
   end

   // State registers; reset drops any read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= ResetPcAligned;
         req_pc_q     <= ResetPcAligned;
         hold_instr_q <= NOP;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

endmodule
